// File: rtl/pcgen_pkg.sv
// Shared types and constants for the fetch-PC generator and its branch target buffer.
package pcgen_pkg;

   localparam int          PC_MAX_W       = 64;
   localparam logic [63:0] PCINIT_DEFAULT = 64'h8000_0000;

   // 2-bit direction counter encoding; bit 1 is the taken prediction
   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   typedef struct packed {
      logic                valid;
      logic [PC_MAX_W-1:0] tag;
      logic [PC_MAX_W-1:0] target;
      logic [1:0]          ctr;
   } btb_entry_t;

endpackage

// File: rtl/pcgen_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC, training from execute.
module pcgen_btb
   import pcgen_pkg::*;
#(
   parameter int PC_WIDTH    = 64,
   parameter int BTB_ENTRIES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-3:0] lookup_word,
   output logic                pred_taken,
   output logic [PC_WIDTH-1:0] pred_target,
   input  logic                upd_valid,
   input  logic [PC_WIDTH-3:0] upd_word,
   input  logic                upd_taken,
   input  logic [PC_WIDTH-1:0] upd_target
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = PC_WIDTH - 2 - IDX;

   logic [BTB_ENTRIES-1:0] valid_q;
   btb_entry_t             entries_q [BTB_ENTRIES];

   logic [IDX-1:0]   lk_idx;
   logic [IDX-1:0]   up_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] up_tag;
   btb_entry_t       lk_entry;
   btb_entry_t       up_entry;
   logic             lk_hit;
   logic             up_hit;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

   assign lk_idx = lookup_word[IDX-1:0];
   assign lk_tag = lookup_word[PC_WIDTH-3:IDX];
   assign up_idx = upd_word[IDX-1:0];
   assign up_tag = upd_word[PC_WIDTH-3:IDX];

   // Valid bits live in their own resettable vector; the payload array carries no reset
   always_comb begin
      lk_entry       = entries_q[lk_idx];
      lk_entry.valid = valid_q[lk_idx];
      lk_hit         = lk_entry.valid && (lk_entry.tag == PC_MAX_W'(lk_tag));
      up_entry       = entries_q[up_idx];
      up_entry.valid = valid_q[up_idx];
      up_hit         = up_entry.valid && (up_entry.tag == PC_MAX_W'(up_tag));
   end

   assign pred_taken  = lk_hit & lk_entry.ctr[1];
   assign pred_target = lk_hit ? lk_entry.target[PC_WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (upd_valid && upd_taken && !up_hit) begin
         valid_q[up_idx] <= 1'b1;
      end
   end

   // Lookup reads the pre-update payload; training lands at the edge
   always_ff @(posedge clk) begin
      if (upd_valid) begin
         if (up_hit) begin
            if (upd_taken) begin
               entries_q[up_idx].ctr    <= ctr_inc(up_entry.ctr);
               entries_q[up_idx].target <= PC_MAX_W'(upd_target);
            end else begin
               entries_q[up_idx].ctr <= ctr_dec(up_entry.ctr);
            end
         end else if (upd_taken) begin
            entries_q[up_idx] <= '{valid:  1'b1,
                                   tag:    PC_MAX_W'(up_tag),
                                   target: PC_MAX_W'(upd_target),
                                   ctr:    WT};
         end
      end
   end

endmodule

// File: rtl/pcgen.sv
// Fetch-PC generator: PC register and next-PC priority select (trap, redirect, stall, BTB, sequential).
module pcgen
   import pcgen_pkg::*;
#(
   parameter int                  PC_WIDTH    = 64,
   parameter logic [PC_WIDTH-1:0] PCINIT      = PC_WIDTH'(PCINIT_DEFAULT),
   parameter int                  FETCH_WIDTH = 1,
   parameter int                  BTB_ENTRIES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stallpc,
   input  logic                trap_valid,
   input  logic [PC_WIDTH-1:0] trap_target,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic                upd_valid,
   input  logic [PC_WIDTH-1:0] upd_pc,
   input  logic                upd_taken,
   input  logic [PC_WIDTH-1:0] upd_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic                pred_taken,
   output logic [PC_WIDTH-1:0] pred_target
);

   localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(FETCH_WIDTH * 4);

   logic [PC_WIDTH-1:0] pc_p0;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic                unused_upd_lsb;

   assign unused_upd_lsb = ^upd_pc[1:0];

   pcgen_btb #(
      .PC_WIDTH    (PC_WIDTH),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .reset       (reset),
      .lookup_word (pc_p0[PC_WIDTH-1:2]),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_word    (upd_pc[PC_WIDTH-1:2]),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target)
   );

   always_comb begin
      pc_nxt = pc_p0 + STEP;
      if (trap_valid) begin
         pc_nxt = trap_target;
      end else if (redirect_valid) begin
         pc_nxt = redirect_target;
      end else if (stallpc) begin
         pc_nxt = pc_p0;
      end else if (pred_taken) begin
         pc_nxt = pred_target;
      end
   end

   // p0: architectural fetch PC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_p0 <= PCINIT;
      end else begin
         pc_p0 <= pc_nxt;
      end
   end

   assign pc = pc_p0;

endmodule

// File: tb/tb_pcgen.sv
// Self-checking bench for pcgen: a default instance and a FETCH_WIDTH=2/BTB_ENTRIES=4 instance share stimulus.
module tb_pcgen;

   localparam logic [63:0] PCI = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallpc, trap_valid, redirect_valid, upd_valid, upd_taken;
   logic [63:0] trap_target, redirect_target, upd_pc, upd_target;
   logic [63:0] pc_a, pred_target_a, pc_b, pred_target_b;
   logic        pred_taken_a, pred_taken_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pcgen u_dut_a (
      .clk(clk), .reset(reset), .stallpc(stallpc),
      .trap_valid(trap_valid), .trap_target(trap_target),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .pc(pc_a), .pred_taken(pred_taken_a), .pred_target(pred_target_a)
   );

   pcgen #(.FETCH_WIDTH(2), .BTB_ENTRIES(4)) u_dut_b (
      .clk(clk), .reset(reset), .stallpc(stallpc),
      .trap_valid(trap_valid), .trap_target(trap_target),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .pc(pc_b), .pred_taken(pred_taken_b), .pred_target(pred_target_b)
   );

   // Reference model: index 0 is the default instance, index 1 the small one
   logic [63:0] mpc  [2];
   bit          mv   [2][16];
   logic [63:0] mtag [2][16];
   logic [63:0] mtgt [2][16];
   int          mctr [2][16];

   function automatic int nent(int d);
      return (d == 0) ? 16 : 4;
   endfunction

   function automatic logic [63:0] stepsz(int d);
      return (d == 0) ? 64'd4 : 64'd8;
   endfunction

   function automatic int m_idx(int d, logic [63:0] a);
      return int'((a >> 2) % 64'(nent(d)));
   endfunction

   function automatic logic [63:0] m_tag(int d, logic [63:0] a);
      return (a >> 2) / 64'(nent(d));
   endfunction

   function automatic void m_lookup(int d, logic [63:0] a, output bit t, output logic [63:0] tg);
      int  i;
      bit  hit;
      i   = m_idx(d, a);
      hit = mv[d][i] && (mtag[d][i] == m_tag(d, a));
      t   = hit && (mctr[d][i] >= 2);
      tg  = hit ? mtgt[d][i] : 64'd0;
   endfunction

   function automatic void m_train(int d, logic [63:0] a, bit taken, logic [63:0] tgt);
      int i;
      i = m_idx(d, a);
      if (mv[d][i] && mtag[d][i] == m_tag(d, a)) begin
         if (taken) begin
            mctr[d][i] = (mctr[d][i] < 3) ? mctr[d][i] + 1 : 3;
            mtgt[d][i] = tgt;
         end else begin
            mctr[d][i] = (mctr[d][i] > 0) ? mctr[d][i] - 1 : 0;
         end
      end else if (taken) begin
         mv[d][i]   = 1'b1;
         mtag[d][i] = m_tag(d, a);
         mtgt[d][i] = tgt;
         mctr[d][i] = 2;
      end
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         mpc[d] = PCI;
         for (int i = 0; i < 16; i++) mv[d][i] = 1'b0;
      end
   endfunction

   task automatic idle();
      stallpc = 0; trap_valid = 0; redirect_valid = 0; upd_valid = 0; upd_taken = 0;
      trap_target = '0; redirect_target = '0; upd_pc = '0; upd_target = '0;
   endtask

   // Called at a negedge with inputs set; advances model and DUT by one clock
   task automatic tick();
      bit          t;
      logic [63:0] tg, nxt;
      for (int d = 0; d < 2; d++) begin
         m_lookup(d, mpc[d], t, tg);
         if (trap_valid)          nxt = trap_target;
         else if (redirect_valid) nxt = redirect_target;
         else if (stallpc)        nxt = mpc[d];
         else if (t)              nxt = tg;
         else                     nxt = mpc[d] + stepsz(d);
         if (upd_valid) m_train(d, upd_pc, upd_taken, upd_target);
         mpc[d] = nxt;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic train(logic [63:0] a, bit taken, logic [63:0] tgt);
      upd_valid = 1; upd_pc = a; upd_taken = taken; upd_target = tgt;
      tick();
      upd_valid = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (pc_a !== PCI) begin errors++; $display("FAIL reset_pc got %h want %h", pc_a, PCI); end
      checks++; if (pred_taken_a !== 1'b0 || pred_target_a !== 64'd0) begin
         errors++; $display("FAIL reset_pred got %b/%h want 0/0", pred_taken_a, pred_target_a); end
      reset = 1;
      tick();
      checks++; if (pc_a !== 64'h8000_0004) begin errors++; $display("FAIL reset_seq1 got %h want 80000004", pc_a); end
      checks++; if (pc_b !== 64'h8000_0008) begin errors++; $display("FAIL reset_seq1_b got %h want 80000008", pc_b); end
      tick();
      checks++; if (pc_a !== 64'h8000_0008 || pred_taken_a !== 1'b0) begin
         errors++; $display("FAIL reset_seq2 got %h/%b want 80000008/0", pc_a, pred_taken_a); end
   endtask

   task automatic test_stall_priority();
      redirect_valid = 1; redirect_target = 64'h8000_0010;
      tick();
      redirect_valid = 0; stallpc = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (pc_a !== 64'h8000_0010 || pc_b !== 64'h8000_0010) begin
            errors++; $display("FAIL stall_hold got %h/%h want 80000010", pc_a, pc_b); end
      end
      redirect_valid = 1; redirect_target = 64'h8000_0100;
      tick();
      checks++; if (pc_a !== 64'h8000_0100) begin errors++; $display("FAIL redirect_over_stall got %h want 80000100", pc_a); end
      idle();
   endtask

   task automatic test_trap_vs_redirect();
      trap_valid = 1; trap_target = 64'h8000_0200;
      redirect_valid = 1; redirect_target = 64'h8000_0300;
      tick();
      checks++; if (pc_a !== 64'h8000_0200 || pc_b !== 64'h8000_0200) begin
         errors++; $display("FAIL trap_wins got %h/%h want 80000200", pc_a, pc_b); end
      idle();
      tick();
      checks++; if (pc_a !== 64'h8000_0204) begin errors++; $display("FAIL redirect_dropped got %h want 80000204", pc_a); end
   endtask

   task automatic test_allocate();
      redirect_valid = 1; redirect_target = 64'h8000_0018;
      train(64'h8000_0020, 1, 64'h8000_0400);
      idle();
      tick();
      tick();
      checks++; if (pc_a !== 64'h8000_0020 || pred_taken_a !== 1'b1 || pred_target_a !== 64'h8000_0400) begin
         errors++; $display("FAIL alloc_predict got %h/%b/%h want 80000020/1/80000400", pc_a, pred_taken_a, pred_target_a); end
      checks++; if (pc_b !== mpc[1]) begin errors++; $display("FAIL alloc_b_pc got %h want %h", pc_b, mpc[1]); end
      tick();
      checks++; if (pc_a !== 64'h8000_0400) begin errors++; $display("FAIL alloc_follow got %h want 80000400", pc_a); end
   endtask

   task automatic test_hysteresis();
      redirect_valid = 1; redirect_target = 64'h8000_0020;
      tick();
      idle();
      stallpc = 1;
      checks++; if (pred_taken_a !== 1'b1) begin errors++; $display("FAIL hyst_start got %b want 1", pred_taken_a); end
      train(64'h8000_0020, 0, 64'h0);
      checks++; if (pc_a !== 64'h8000_0020) begin errors++; $display("FAIL stall_over_pred got %h want 80000020", pc_a); end
      checks++; if (pred_taken_a !== 1'b0) begin errors++; $display("FAIL hyst_ctr1 got %b want 0", pred_taken_a); end
      upd_valid = 1; upd_pc = 64'h8000_0020; upd_taken = 1; upd_target = 64'h8000_0400;
      checks++; if (pred_taken_a !== 1'b0) begin errors++; $display("FAIL same_cycle_pre got %b want 0", pred_taken_a); end
      tick();
      upd_valid = 0;
      checks++; if (pred_taken_a !== 1'b1) begin errors++; $display("FAIL hyst_ctr2 got %b want 1", pred_taken_a); end
      train(64'h8000_0020, 1, 64'h8000_0400);
      train(64'h8000_0020, 1, 64'h8000_0400);
      train(64'h8000_0020, 0, 64'h0);
      checks++; if (pred_taken_a !== 1'b1) begin errors++; $display("FAIL hyst_sat3_dec got %b want 1", pred_taken_a); end
      train(64'h8000_0020, 0, 64'h0);
      checks++; if (pred_taken_a !== 1'b0) begin errors++; $display("FAIL hyst_ctr1b got %b want 0", pred_taken_a); end
      train(64'h8000_0020, 0, 64'h0);
      train(64'h8000_0020, 0, 64'h0);
      train(64'h8000_0020, 1, 64'h8000_0400);
      checks++; if (pred_taken_a !== 1'b0) begin errors++; $display("FAIL hyst_sat0_inc got %b want 0", pred_taken_a); end
      train(64'h8000_0020, 1, 64'h8000_0480);
      checks++; if (pred_taken_a !== 1'b1 || pred_target_a !== 64'h8000_0480) begin
         errors++; $display("FAIL hyst_retarget got %b/%h want 1/80000480", pred_taken_a, pred_target_a); end
      train(64'h8000_0020, 1, 64'h8000_0480);
      train(64'h8000_0020, 0, 64'h8000_0700);
      checks++; if (pred_taken_a !== 1'b1 || pred_target_a !== 64'h8000_0480) begin
         errors++; $display("FAIL hyst_nt_keeps_target got %b/%h want 1/80000480", pred_taken_a, pred_target_a); end
      idle();
   endtask

   task automatic test_alias_step();
      redirect_valid = 1; redirect_target = 64'h8000_0030;
      tick();
      idle();
      checks++; if (pred_taken_b !== 1'b0 || pred_target_b !== 64'd0) begin
         errors++; $display("FAIL alias_miss got %b/%h want 0/0", pred_taken_b, pred_target_b); end
      tick();
      checks++; if (pc_a !== 64'h8000_0034 || pc_b !== 64'h8000_0038) begin
         errors++; $display("FAIL step_size got %h/%h want 80000034/80000038", pc_a, pc_b); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1; redirect_target = 64'hFFFF_FFFF_FFFF_FFF8;
      tick();
      idle();
      tick();
      checks++; if (pc_b !== 64'd0) begin errors++; $display("FAIL wrap_b got %h want 0", pc_b); end
      checks++; if (pc_a !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_a_pre got %h want fffffffffffffffc", pc_a); end
      tick();
      checks++; if (pc_a !== 64'd0) begin errors++; $display("FAIL wrap_a got %h want 0", pc_a); end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2 reset = 0;
      #1;
      checks++; if (pc_a !== PCI || pc_b !== PCI || pred_taken_a !== 1'b0) begin
         errors++; $display("FAIL async_reset got %h/%h/%b want 80000000", pc_a, pc_b, pred_taken_a); end
      model_reset();
      @(negedge clk);
      reset = 1;
      tick();
      checks++; if (pc_a !== 64'h8000_0004) begin errors++; $display("FAIL post_reset_seq got %h want 80000004", pc_a); end
      redirect_valid = 1; redirect_target = 64'h8000_0020;
      tick();
      idle();
      checks++; if (pred_taken_a !== 1'b0 || pred_target_a !== 64'd0) begin
         errors++; $display("FAIL btb_cleared got %b/%h want 0/0", pred_taken_a, pred_target_a); end
   endtask

   task automatic test_random();
      bit          t;
      logic [63:0] tg;
      for (int n = 0; n < 400; n++) begin
         trap_valid      = ($urandom_range(0, 19) == 0);
         trap_target     = PCI + 64'($urandom_range(0, 63) * 4);
         redirect_valid  = ($urandom_range(0, 9) == 0);
         redirect_target = PCI + 64'($urandom_range(0, 255));
         stallpc         = ($urandom_range(0, 4) == 0);
         upd_valid       = ($urandom_range(0, 1) == 1);
         upd_pc          = PCI + 64'($urandom_range(0, 63) * 4);
         upd_taken       = ($urandom_range(0, 2) != 0);
         upd_target      = PCI + 64'($urandom_range(0, 63) * 4);
         m_lookup(0, mpc[0], t, tg);
         checks++; if (pc_a !== mpc[0] || pred_taken_a !== t || pred_target_a !== tg) begin
            errors++;
            if (errors < 20) $display("FAIL rand_a cyc %0d got %h/%b/%h want %h/%b/%h", n, pc_a, pred_taken_a, pred_target_a, mpc[0], t, tg);
         end
         m_lookup(1, mpc[1], t, tg);
         checks++; if (pc_b !== mpc[1] || pred_taken_b !== t || pred_target_b !== tg) begin
            errors++;
            if (errors < 20) $display("FAIL rand_b cyc %0d got %h/%b/%h want %h/%b/%h", n, pc_b, pred_taken_b, pred_target_b, mpc[1], t, tg);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_stall_priority();
      test_trap_vs_redirect();
      test_allocate();
      test_hysteresis();
      test_alias_step();
      test_wrap();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcgen.md
# pcgen

Parametrised fetch-PC generator for the fetch stage. Holds the architectural fetch PC and selects the next PC each cycle from these sources, in priority order: trap, execute redirect, stall hold, BTB prediction, sequential increment. It contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained from execute. Its outputs drive the instruction-fetch request and the predicted-taken tag carried down the pipe.

## Interface
- PC_WIDTH, 64, width of PC and targets
- PCINIT, 64'h8000_0000, PC value on reset
- FETCH_WIDTH, 1, instructions per fetch group; sequential step = FETCH_WIDTH*4 bytes
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- stallpc  in  1  hold PC (fetch back-pressure)
- trap_valid  in  1  trap/exception redirect
- trap_target  in  PC_WIDTH  trap vector
- redirect_valid  in  1  execute mispredict redirect
- redirect_target  in  PC_WIDTH  corrected PC
- upd_valid  in  1  BTB training strobe from execute
- upd_pc  in  PC_WIDTH  PC of resolved branch
- upd_taken  in  1  resolved direction
- upd_target  in  PC_WIDTH  resolved target
- pc  out  PC_WIDTH  current fetch PC
- pred_taken  out  1  BTB predicts current pc taken
- pred_target  out  PC_WIDTH  predicted target (valid when pred_taken)

## Operation
- IDX = log2(BTB_ENTRIES). Index = pc[IDX+1:2]. Tag = pc[PC_WIDTH-1:IDX+2].
- Entry fields: valid, tag, target, ctr[1:0].
- Lookup (combinational on current pc): hit = valid & tag match. pred_taken = hit & ctr[1]. pred_target = entry target. When not hit, pred_target = 0.
- Next-PC priority:
  1. trap_valid → trap_target.
  2. redirect_valid → redirect_target.
  3. stallpc → pc (hold).
  4. pred_taken → pred_target.
  5. otherwise → pc + FETCH_WIDTH*4.
- Trap and redirect override stallpc.
- Targets load verbatim; no alignment check.
- Sequential add wraps modulo 2^PC_WIDTH.
- Training when upd_valid, on entry upd_pc[IDX+1:2]:
  - Tag hit, taken: ctr saturating +1 (max 3); target ← upd_target.
  - Tag hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - Tag miss, taken: allocate. valid=1, tag, target=upd_target, ctr=2.
  - Tag miss, not taken: no change.
- Lookup and training can address the same entry in the same cycle. Lookup then returns the pre-update contents; the update is visible from the next cycle.

## Timing
- Reset asserted (low), asynchronously:
  - pc = PCINIT.
  - All BTB valid bits = 0; pred_taken = 0 and pred_target = 0 while in reset and until training occurs.
- Single-cycle latency. Any select condition sampled at posedge t produces the new pc after posedge t, visible during cycle t+1.
- The BTB prediction is computed from the pc of the same cycle. A hit at cycle t gives pc = pred_target in cycle t+1.
- Reset deasserted mid-operation: the first posedge after deassertion applies normal selection starting from PCINIT.
- trap_valid and redirect_valid together: trap wins; the redirect is dropped, with no queuing.
- Training with PC_WIDTH-wide tags means aliasing occurs only within the index bits.

## Structure
- Shared package holds:
  - PCINIT default
  - the btb_entry_t struct (valid, tag, target, ctr)
  - the ctr encoding constants: SNT=0, WNT=1, WT=2, ST=3
- Sub-module pcgen_btb contains the storage array, lookup port and training port.
- pcgen contains only the PC register and priority mux.

## Test plan
- Reset: hold reset low for 3 cycles, release, no other stimulus → pc = 8000_0000, then 8000_0004, 8000_0008; pred_taken stays 0.
- Stall and priority:
  - stallpc=1 for 2 cycles at pc=8000_0010 → pc holds 8000_0010.
  - Then assert stallpc=1 together with redirect_valid (target 8000_0100) → next pc = 8000_0100.
- Trap vs redirect: trap_valid (trap_target=8000_0200) and redirect_valid (redirect_target=8000_0300) in the same cycle → next pc = 8000_0200.
- Allocate and predict:
  - Train upd_pc=8000_0020, taken, target=8000_0400.
  - Then run sequentially to 8000_0020 → pred_taken=1 and next pc = 8000_0400.
- Counter hysteresis, after the allocate step:
  - Train 8000_0020 not-taken once → ctr=1, pred_taken=0.
  - Train taken twice → ctr=3.
  - Train not-taken once → ctr=2, still predicts taken.
- Aliasing and parameters:
  - FETCH_WIDTH=2, BTB_ENTRIES=4: step is 8.
  - Trained entry 8000_0020 versus lookup at 8000_0030 (same index, different tag) → no hit.
  - pc=FFFF_FFFF_FFFF_FFF8 wraps to 0.
